// File: rtl/eq_pkg.sv
// Shared constants and state encoding for the histogram-equalization LUT builder.
package eq_pkg;

  localparam int unsigned NUM_BINS          = 256;
  localparam int unsigned BINS_PER_CDF_WORD = 4;
  localparam int unsigned BINS_PER_LUT_WORD = 16;
  localparam int unsigned CDF_LANE_W        = 32;
  localparam int unsigned CDF_VAL_W         = 20;
  localparam int unsigned LUT_VAL_W         = 8;
  localparam int unsigned LUT_MAX           = 255;
  localparam int unsigned ADDR_W            = 16;

  localparam int unsigned CDF_WORD_W = BINS_PER_CDF_WORD * CDF_LANE_W;
  localparam int unsigned LUT_WORD_W = BINS_PER_LUT_WORD * LUT_VAL_W;
  localparam int unsigned BIN_W      = $clog2(NUM_BINS);
  localparam int unsigned LANE_W     = $clog2(BINS_PER_CDF_WORD);
  localparam int unsigned SLOT_W     = $clog2(BINS_PER_LUT_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_CALC,
    ST_PACK,
    ST_WRITE,
    ST_DONE
  } eq_state_e;

endpackage

// File: rtl/eq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done exactly NUM_W+1 cycles after start.
module eq_divider #(
  parameter int unsigned NUM_W = 29,
  parameter int unsigned DEN_W = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_r;
  logic [NUM_W-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   diff;
  logic             fits;
  logic             unused_diff_msb;

  // Shift in the next dividend bit and trial-subtract the divisor.
  assign rem_sh          = {rem, quo[NUM_W-1]};
  assign diff            = rem_sh - {1'b0, den_r};
  assign fits            = (rem_sh >= {1'b0, den_r});
  assign unused_diff_msb = diff[DEN_W];
  assign quotient        = quo;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem     <= '0;
      den_r   <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        den_r   <= den;
        quo     <= num;
        cnt     <= CNT_W'(NUM_W);
        running <= 1'b1;
      end else if (running) begin
        if (cnt != '0) begin
          rem <= fits ? diff[DEN_W-1:0] : rem_sh[DEN_W-1:0];
          quo <= {quo[NUM_W-2:0], fits};
          cnt <= cnt - CNT_W'(1);
        end else begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdf_equalize_map.sv
// Reads a finished CDF from scratchpad and writes the packed histogram-equalization LUT,
// one bin at a time through a shared sequential divider.
module cdf_equalize_map
  import eq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CDF_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] LUT_BASE  = 16'h0100,
  parameter int unsigned       DIV_WIDTH = 29
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cdf_valid,
  input  logic [CDF_VAL_W-1:0]  Cdf_Min,
  input  logic [CDF_VAL_W-1:0]  pixel_count,
  output logic [ADDR_W-1:0]     CDF_ReadAddress,
  input  logic [CDF_WORD_W-1:0] CDF_ReadBus,
  output logic [LUT_WORD_W-1:0] LUT_WriteBus,
  output logic [ADDR_W-1:0]     LUT_WriteAddress,
  output logic                  LUT_WriteEnable,
  output logic                  busy,
  output logic                  done
);

  eq_state_e                                    state;
  logic [BIN_W-1:0]                             bin;
  logic [CDF_VAL_W-1:0]                         cdf_min_r;
  logic [CDF_VAL_W-1:0]                         denom_r;
  logic [BINS_PER_CDF_WORD-1:0][CDF_VAL_W-1:0]  cdf_hold;
  logic [LUT_WORD_W-1:0]                        lut_sr;
  logic [LUT_WORD_W-1:0]                        lut_next_c;
  logic [LUT_VAL_W-1:0]                         byte_r;
  logic [LUT_VAL_W-1:0]                         sat_c;
  logic                                         div_start;
  logic                                         div_wait;
  logic                                         div_done;
  logic [DIV_WIDTH-1:0]                         num_c;
  logic [DIV_WIDTH-1:0]                         div_q;
  logic [LANE_W-1:0]                            lane;
  logic [SLOT_W-1:0]                            slot;
  logic [CDF_VAL_W-1:0]                         cur_cdf;
  logic                                         clamp_c;
  logic                                         unused_lane_bits;

  assign lane    = bin[LANE_W-1:0];
  assign slot    = bin[SLOT_W-1:0];
  assign cur_cdf = cdf_hold[lane];

  // Bins at or below cdf_min, or a single-valued image, map straight to 0.
  assign clamp_c = (cur_cdf <= cdf_min_r) || (denom_r == '0);
  assign num_c   = DIV_WIDTH'(CDF_VAL_W'(cur_cdf - cdf_min_r)) * DIV_WIDTH'(LUT_MAX)
                 + DIV_WIDTH'(denom_r >> 1);
  assign sat_c   = (div_q > DIV_WIDTH'(LUT_MAX)) ? LUT_VAL_W'(LUT_MAX)
                                                 : div_q[LUT_VAL_W-1:0];

  always_comb begin
    lut_next_c = lut_sr;
    lut_next_c[slot*LUT_VAL_W +: LUT_VAL_W] = byte_r;
  end

  // Upper 12 bits of each CDF lane carry no information.
  always_comb begin
    unused_lane_bits = 1'b0;
    for (int j = 0; j < BINS_PER_CDF_WORD; j++) begin
      unused_lane_bits = unused_lane_bits
                       ^ (^CDF_ReadBus[j*CDF_LANE_W+CDF_VAL_W +: CDF_LANE_W-CDF_VAL_W]);
    end
  end

  eq_divider #(
    .NUM_W (DIV_WIDTH),
    .DEN_W (CDF_VAL_W)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .num      (num_c),
    .den      (denom_r),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      bin              <= '0;
      cdf_min_r        <= '0;
      denom_r          <= '0;
      cdf_hold         <= '0;
      lut_sr           <= '0;
      byte_r           <= '0;
      div_start        <= 1'b0;
      div_wait         <= 1'b0;
      CDF_ReadAddress  <= '0;
      LUT_WriteBus     <= '0;
      LUT_WriteAddress <= '0;
      LUT_WriteEnable  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      LUT_WriteEnable <= 1'b0;
      done            <= 1'b0;
      div_start       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && cdf_valid) begin
            cdf_min_r <= Cdf_Min;
            denom_r   <= pixel_count - Cdf_Min;
            bin       <= '0;
            lut_sr    <= '0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          CDF_ReadAddress <= CDF_BASE + ADDR_W'(bin[BIN_W-1:LANE_W]);
          state           <= ST_WAIT;
        end
        ST_WAIT: state <= ST_LOAD;
        ST_LOAD: begin
          for (int j = 0; j < BINS_PER_CDF_WORD; j++) begin
            cdf_hold[j] <= CDF_ReadBus[j*CDF_LANE_W +: CDF_VAL_W];
          end
          state <= ST_CALC;
        end
        ST_CALC: begin
          if (clamp_c) begin
            byte_r <= '0;
            state  <= ST_PACK;
          end else if (!div_wait) begin
            div_start <= 1'b1;
            div_wait  <= 1'b1;
          end else if (div_done) begin
            div_wait <= 1'b0;
            byte_r   <= sat_c;
            state    <= ST_PACK;
          end
        end
        ST_PACK: begin
          lut_sr <= lut_next_c;
          if (slot == SLOT_W'(BINS_PER_LUT_WORD - 1)) begin
            LUT_WriteEnable  <= 1'b1;
            LUT_WriteBus     <= lut_next_c;
            LUT_WriteAddress <= LUT_BASE + ADDR_W'(bin[BIN_W-1:SLOT_W]);
            state            <= ST_WRITE;
          end else begin
            bin   <= bin + BIN_W'(1);
            state <= (lane == LANE_W'(BINS_PER_CDF_WORD - 1)) ? ST_FETCH : ST_CALC;
          end
        end
        ST_WRITE: begin
          if (bin == BIN_W'(NUM_BINS - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            bin   <= bin + BIN_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
